// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one single-port synchronous SRAM (1-cycle read latency) between the
//   instruction-fetch requester (if_*) and the load/store requester (ds_*).
//   Grants are combinational, at most one per cycle. Read data is routed back
//   to the owner of each access exactly one cycle after its grant.
//
//   Ports:
//     clk, resetn                         clock (rising edge), async active-low reset
//     if_req, if_addr                     fetch read request
//     if_gnt, if_rvalid, if_rdata         fetch grant (comb), return valid/data (registered valid)
//     ds_req, ds_we, ds_addr, ds_wdata    data request; ds_we==0 is a read
//     ds_gnt, ds_rvalid, ds_rdata         data grant (comb), return valid/data (registered valid)
//     mem_en, mem_we, mem_addr, mem_wdata SRAM command port
//     mem_rdata                           SRAM read data, valid the cycle after a read
//
//   Build option: define ARB_RR_EN to arbitrate contention round-robin instead
//   of fixed data priority with the STARVE_MAX fetch starvation guard.

module sram_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int AW         = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    input  logic          ds_req,
    input  logic [3:0]    ds_we,
    input  logic [AW-1:0] ds_addr,
    input  logic [31:0]   ds_wdata,
    output logic          ds_gnt,
    output logic          ds_rvalid,
    output logic [31:0]   ds_rdata,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DS = 1'b1;

    logic r_pend_valid;
    logic r_pend_owner;
    logic w_if_win;
    logic w_ds_win;

`ifdef ARB_RR_EN
    // Last contended winner; reset value OWN_IF hands the first tie to ds.
    logic r_rr_last;

    always_comb begin
        w_if_win = if_req & (~ds_req | (r_rr_last == OWN_DS));
        w_ds_win = ds_req & (~if_req | (r_rr_last == OWN_IF));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rr_last <= OWN_IF;
        end else if (if_req && ds_req) begin
            r_rr_last <= if_gnt ? OWN_IF : OWN_DS;
        end
    end
`else
    localparam logic [3:0] STARVE_LIM = STARVE_MAX[3:0];

    logic [3:0] r_starve_cnt;
    logic       w_fetch_force;

    always_comb begin
        w_fetch_force = (r_starve_cnt == STARVE_LIM);
        w_if_win      = if_req & (~ds_req | w_fetch_force);
        w_ds_win      = ds_req & ~(if_req & w_fetch_force);
    end

    // Counts cycles fetch has been held off by data; saturates at the limit,
    // where fetch_force lets fetch take the next contended cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_starve_cnt <= '0;
        end else if (if_gnt || !if_req) begin
            r_starve_cnt <= '0;
        end else if (ds_gnt && (r_starve_cnt != STARVE_LIM)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end
`endif

    // Grants are held low combinationally while reset is asserted.
    always_comb begin
        if_gnt = resetn & w_if_win;
        ds_gnt = resetn & w_ds_win;
        mem_en = if_gnt | ds_gnt;
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 4'b0000;
        mem_wdata = 32'h0;
        if (if_gnt) begin
            mem_addr = if_addr;
        end else if (ds_gnt) begin
            mem_addr  = ds_addr;
            mem_we    = ds_we;
            mem_wdata = ds_wdata;
        end
    end

    // Owner tracker for the read issued last cycle; writes produce no return.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pend_valid <= 1'b0;
            r_pend_owner <= OWN_IF;
        end else if (if_gnt) begin
            r_pend_valid <= 1'b1;
            r_pend_owner <= OWN_IF;
        end else if (ds_gnt && (ds_we == 4'b0000)) begin
            r_pend_valid <= 1'b1;
            r_pend_owner <= OWN_DS;
        end else begin
            r_pend_valid <= 1'b0;
        end
    end

    always_comb begin
        if_rvalid = r_pend_valid & (r_pend_owner == OWN_IF);
        ds_rvalid = r_pend_valid & (r_pend_owner == OWN_DS);
        if_rdata  = if_rvalid ? mem_rdata : 32'h0;
        ds_rdata  = ds_rvalid ? mem_rdata : 32'h0;
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ds_req;
    logic [3:0]  ds_we;
    logic [31:0] ds_addr, ds_wdata;
    logic        ds_gnt, ds_rvalid;
    logic [31:0] ds_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic        own;   // 0 = IF, 1 = DS
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    sram_port_arbiter #(.STARVE_MAX(4), .AW(32)) dut (
        .clk(clk), .resetn(resetn),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ds_req(ds_req), .ds_we(ds_we), .ds_addr(ds_addr), .ds_wdata(ds_wdata),
        .ds_gnt(ds_gnt), .ds_rvalid(ds_rvalid), .ds_rdata(ds_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // SRAM model: word index from addr[9:2], byte writes, 1-cycle read latency.
    logic [31:0] mem [256];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we == 4'b0000) begin
                mem_rdata <= mem[mem_addr[9:2]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (mem_we[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents read data.
    always @(negedge clk) begin
        if (resetn === 1'b1 && (if_rvalid === 1'b1 || ds_rvalid === 1'b1)) begin
            if (if_rvalid && ds_rvalid) begin
                chk("both_rvalid", {if_rvalid, ds_rvalid}, 32'b01);
            end else if (sb.size() == 0) begin
                chk("unexpected_rvalid", {if_rvalid, ds_rvalid}, 32'b00);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ret_owner", {31'b0, ds_rvalid}, {31'b0, e.own});
                if (e.own) begin
                    chk("ds_rdata", ds_rdata, e.data);
                    chk("if_rdata_nonowner", if_rdata, 32'h0);
                end else begin
                    chk("if_rdata", if_rdata, e.data);
                    chk("ds_rdata_nonowner", ds_rdata, 32'h0);
                end
            end
        end
    end

    // One request cycle: drive at negedge, check combinational grant/SRAM drive,
    // and push the expected return for read grants.
    task automatic cyc(input string nm,
                       input logic ir, input logic [31:0] ia,
                       input logic dr, input logic [3:0] dw, input logic [31:0] da,
                       input logic [31:0] dd,
                       input logic eig, input logic edg, input logic [31:0] erd);
        exp_t e;
        @(negedge clk);
        if_req = ir; if_addr = ia;
        ds_req = dr; ds_we = dw; ds_addr = da; ds_wdata = dd;
        #1;
        chk({nm, "_gnt"}, {30'b0, if_gnt, ds_gnt}, {30'b0, eig, edg});
        chk({nm, "_en"}, {31'b0, mem_en}, {31'b0, eig | edg});
        if (eig) begin
            chk({nm, "_addr"}, mem_addr, ia);
            chk({nm, "_we"}, {28'b0, mem_we}, 32'h0);
        end else if (edg) begin
            chk({nm, "_addr"}, mem_addr, da);
            chk({nm, "_we"}, {28'b0, mem_we}, {28'b0, dw});
            chk({nm, "_wdata"}, mem_wdata, dd);
        end else begin
            chk({nm, "_idle_drive"}, mem_addr | mem_wdata | {28'b0, mem_we}, 32'h0);
        end
        if (eig || (edg && dw == 4'b0000)) begin
            e.own = edg;
            e.data = erd;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc("idle", 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

`ifdef ARB_RR_EN
    logic exp_if_seq [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
    logic exp_if_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0]   = 32'h02800C0C;   // 0x1C000000
        mem[1]   = 32'hA1A1A1A1;   // 0x1C000004
        mem[16]  = 32'hD0D0D0D0;   // 0x40
        mem[128] = 32'h11223344;   // 0x200
        mem_rdata = 32'h0;

        // Reset with both requests active: no grants, no returns.
        resetn = 1'b0;
        if_req = 1'b1; if_addr = 32'h1C000000;
        ds_req = 1'b1; ds_we = 4'h0; ds_addr = 32'h40; ds_wdata = 32'h0;
        #12;
        chk("rst_gnt", {30'b0, if_gnt, ds_gnt}, 32'h0);
        chk("rst_en", {31'b0, mem_en}, 32'h0);
        chk("rst_rvalid", {30'b0, if_rvalid, ds_rvalid}, 32'h0);
        if_req = 1'b0; ds_req = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        idle(2);

        // Fetch only.
        cyc("fetch", 1'b1, 32'h1C000000, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h02800C0C);
        idle(2);

        // Contention: both read every cycle for 10 cycles.
        for (int i = 0; i < 10; i++)
            cyc("cont", 1'b1, 32'h1C000004, 1'b1, 4'h0, 32'h40, 32'h0,
                exp_if_seq[i], ~exp_if_seq[i],
                exp_if_seq[i] ? 32'hA1A1A1A1 : 32'hD0D0D0D0);
        idle(2);

        // Store then load to the same address.
        cyc("store", 1'b0, 32'h0, 1'b1, 4'b1111, 32'h100, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0);
        cyc("load", 1'b0, 32'h0, 1'b1, 4'b0000, 32'h100, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        idle(2);

        // Byte store then read back.
        cyc("bstore", 1'b0, 32'h0, 1'b1, 4'b0010, 32'h200, 32'h0000AB00, 1'b0, 1'b1, 32'h0);
        cyc("bload", 1'b0, 32'h0, 1'b1, 4'b0000, 32'h200, 32'h0, 1'b0, 1'b1, 32'h1122AB44);
        idle(2);

        // Async reset between a fetch grant and its return.
        cyc("fetch_r", 1'b1, 32'h1C000000, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h02800C0C);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk("mid_rst_rvalid", {30'b0, if_rvalid, ds_rvalid}, 32'h0);
        chk("mid_rst_gnt", {30'b0, if_gnt, ds_gnt, mem_en}, 32'h0);
        sb.delete();
        if_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_rvalid", {30'b0, if_rvalid, ds_rvalid}, 32'h0);
        cyc("fetch_post", 1'b1, 32'h1C000000, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h02800C0C);
        idle(1);

        // Drain: every expected return must have appeared.
        for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
        chk("sb_empty", sb.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port synchronous SRAM (1-cycle read latency) between the instruction-fetch requester and the data-access (load/store) requester.
- Sits between the IF stage, the MEM-stage data interface and the physical SRAM in the CPU top.
- Issues grants, drives the SRAM port and routes read data back to the owner of each access.
- Drives the fetch-grant signal that the IF stage consumes as its "fetch may proceed" indication.

Parameters:
- STARVE_MAX, 4: consecutive denied fetch cycles after which fetch is forced to win. Legal range 1..15.
- AW, 32: address width.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch read request.
- if_addr  in  AW  fetch address.
- if_gnt  out  1  fetch granted this cycle (combinational); IF uses it as its read-grant input.
- if_rvalid  out  1  fetch read data valid (registered).
- if_rdata  out  32  fetch read data.
- ds_req  in  1  data request.
- ds_we  in  4  byte write enables; 0 = read.
- ds_addr  in  AW  data address.
- ds_wdata  in  32  store data.
- ds_gnt  out  1  data granted this cycle (combinational).
- ds_rvalid  out  1  data read data valid (registered).
- ds_rdata  out  32  data read data.
- mem_en  out  1  SRAM enable.
- mem_we  out  4  SRAM byte write enables.
- mem_addr  out  AW  SRAM address.
- mem_wdata  out  32  SRAM write data.
- mem_rdata  in  32  SRAM read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset (resetn low, asynchronous):
  - starve_cnt=0, pend_valid=0, pend_owner=0, rr_last=0.
  - if_rvalid=0 and ds_rvalid=0 immediately.
  - Grants and mem_en are forced to 0 while resetn is low.
- Grant, combinational, at most one per cycle:
  - fetch_force = (starve_cnt == STARVE_MAX).
  - Both requesting: ds wins unless fetch_force, in which case if wins.
  - Single requester: that requester wins. No request: no grant, mem_en=0.
- SRAM drive:
  - mem_en = if_gnt | ds_gnt.
  - if_gnt: mem_addr=if_addr, mem_we=0, mem_wdata=0.
  - ds_gnt: mem_addr=ds_addr, mem_we=ds_we, mem_wdata=ds_wdata.
  - No grant: address/data outputs are 0.
- Starvation counter, updated on clk:
  - Cleared if if_gnt or !if_req.
  - Otherwise incremented when if_req & ds_gnt, saturating at STARVE_MAX.
- Pending-return state (owner tracker, two flops), updated on clk:
  - Any read grant (if_gnt, or ds_gnt with ds_we==0): pend_valid<=1, pend_owner<=(if_gnt ? IF : DS).
  - Write grant or no grant: pend_valid<=0.
- Return, latency exactly 1 cycle after grant:
  - if_rvalid = pend_valid & pend_owner==IF; ds_rvalid = pend_valid & pend_owner==DS.
  - rdata to the non-owner is 0; owner gets mem_rdata.
  - Each rvalid is a one-cycle pulse; requesters must capture it (no back-pressure).
- Throughput: back-to-back grants every cycle. The return of access N overlaps the grant of access N+1.
- Writes: no rvalid, complete on the grant cycle. Store-then-load to the same address returns the new data, because SRAM order is preserved.
- Requests are sampled only on the grant cycle. A requester that drops req before grant is simply not served.
- Reset mid-operation: an in-flight read's return is discarded and no rvalid is produced after resetn rises.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: on contention, a round-robin pointer picks the winner.
  - rr_last is a 1-bit register updated to the winner on every contended grant.
  - The winner is the requester not equal to rr_last. Ties after reset go to ds.
  - starve_cnt is not implemented; fetch_force is 0.
- Undefined: fixed data priority with the STARVE_MAX starvation guard, as above.

Test Plan:
- Fetch only: if_req=1, if_addr=0x1C000000, mem holds 0x02800C0C -> if_gnt=1 and mem_en=1 in the same cycle; next cycle if_rvalid=1, if_rdata=0x02800C0C, ds_rvalid=0.
- Contention, default build: if_req and ds_req (read) both held 1 for 10 cycles, STARVE_MAX=4 -> grant sequence ds,ds,ds,ds,if repeating; each rvalid follows its owner one cycle later.
- Contention, ARB_RR_EN build: same stimulus -> grants strictly alternate ds,if,ds,if,...
- Store then load: ds_we=4'b1111, addr 0x100, wdata 0xDEADBEEF, then ds read of 0x100 -> no rvalid after the store; ds_rvalid=1 with ds_rdata=0xDEADBEEF one cycle after the load grant.
- Byte store: ds_we=4'b0010, wdata 0x0000AB00 over existing 0x11223344 -> mem_we=4'b0010 on the grant; a subsequent read returns 0x1122AB44.
- Async reset mid-read: assert resetn=0 between a fetch grant and its return -> if_rvalid=0 immediately; no rvalid after release; first grant after release behaves as from idle.
